led_serializer: RTL



---
 rtl/led_serializer.sv | 99 +++++++++
 1 files changed

// File: rtl/led_serializer.sv
// led_serializer: valid/ready word-to-serial shifter with divided sclk and frame latch pulse.
// Define LED_SERIALIZER_LSB_FIRST_EN to shift words out LSB-first.
module led_serializer #(
  parameter int DATA_WIDTH      = 16,
  parameter int CLK_FACTOR      = 4,
  parameter int WORDS_PER_LATCH = 16,
  parameter int LAT_CYCLES      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sclk,
  output logic                  o_sdata,
  output logic                  o_lat,
  output logic                  o_busy
);
  localparam int H  = CLK_FACTOR / 2;
  localparam int TW = $clog2(CLK_FACTOR + LAT_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int WW = $clog2(WORDS_PER_LATCH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, sh_adv;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [WW-1:0]         word_q, word_d;
  logic                  sclk_q, sclk_d, sdata_q, sdata_d, lat_q, lat_d;
  logic                  last_word;
`ifdef LED_SERIALIZER_LSB_FIRST_EN
  localparam int OB = 0;
  assign sh_adv = {1'b0, sh_q[DATA_WIDTH-1:1]};
`else
  localparam int OB = DATA_WIDTH - 1;
  assign sh_adv = {sh_q[DATA_WIDTH-2:0], 1'b0};
`endif
  assign last_word = word_q == WW'(WORDS_PER_LATCH - 1);
  // The timer doubles as the latch-length counter; it is already 0 on LATCH entry.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    word_d  = word_q;
    if (state_q == IDLE) begin
      if (i_valid) begin
        state_d = SHIFT;
        sh_d    = i_data;
        tmr_d   = '0;
        bit_d   = '0;
      end
    end else if (state_q == SHIFT) begin
      if (tmr_q == TW'(CLK_FACTOR - 1)) begin
        tmr_d = '0;
        sh_d  = sh_adv;
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          state_d = last_word ? LATCH : IDLE;
          word_d  = last_word ? '0 : word_q + 1'b1;
        end
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end else begin
      state_d = tmr_q == TW'(LAT_CYCLES - 1) ? IDLE : LATCH;
      tmr_d   = tmr_q + 1'b1;
    end
    sclk_d  = state_d == SHIFT && tmr_d >= TW'(H);
    sdata_d = state_d == SHIFT && sh_d[OB];
    lat_d   = state_d == LATCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      tmr_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      lat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      lat_q   <= lat_d;
    end
  end
  assign o_ready = state_q == IDLE && !rst;
  assign o_busy  = state_q != IDLE;
  assign o_sclk  = sclk_q;
  assign o_sdata = sdata_q;
  assign o_lat   = lat_q;
endmodule
